// File: rtl/vcache_perf_counter_bank.sv
// Performance-counter bank for N vcache channels: saturating per-channel event counters,
// atomic snapshot into shadow registers, and a channel-major record dump over valid/yumi.
module vcache_perf_counter_bank #(
    parameter int num_cache_p     = 4,
    parameter int ctr_width_p     = 32,
    parameter int tag_width_p     = 32,
    parameter int clear_on_snap_p = 1,
    localparam int chan_w_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [num_cache_p-1:0] v_o_i,
    input  logic [num_cache_p-1:0] yumi_i,
    input  logic [num_cache_p-1:0] v_v_r_i,
    input  logic [num_cache_p-1:0] miss_v_i,
    input  logic [num_cache_p-1:0] ld_op_i,
    input  logic [num_cache_p-1:0] st_op_i,
    input  logic                   snap_v_i,
    input  logic [tag_width_p-1:0] snap_tag_i,
    output logic                   busy_o,
    output logic                   dump_v_o,
    input  logic                   dump_yumi_i,
    output logic [chan_w_lp-1:0]   dump_chan_o,
    output logic [2:0]             dump_evt_o,
    output logic [ctr_width_p-1:0] dump_count_o,
    output logic [tag_width_p-1:0] dump_tag_o,
    output logic [ctr_width_p-1:0] snap_drop_o
);

    localparam int num_evt_lp = 5;

    typedef enum logic {IDLE, DUMP} state_e;

    state_e                 state_q;
    logic [chan_w_lp-1:0]   chan_q;
    logic [2:0]             evt_q;
    logic [tag_width_p-1:0] tag_q;
    logic [ctr_width_p-1:0] drop_q;

    logic [ctr_width_p-1:0] live_q   [num_cache_p][num_evt_lp];
    logic [ctr_width_p-1:0] live_d   [num_cache_p][num_evt_lp];
    logic [ctr_width_p-1:0] shadow_q [num_cache_p][num_evt_lp];
    logic [num_evt_lp-1:0]  evt_fire [num_cache_p];

    logic snap_accept;
    logic last_rec;

    assign snap_accept = (state_q == IDLE) && snap_v_i;
    assign last_rec    = (chan_q == chan_w_lp'(num_cache_p - 1)) && (evt_q == 3'd4);

    // Event bit order matches the dump event code: ld, st, ld_miss, st_miss, miss_cycles.
    always_comb begin
        for (int c = 0; c < num_cache_p; c++) begin
            evt_fire[c][0] = v_o_i[c] & yumi_i[c] & ld_op_i[c];
            evt_fire[c][1] = v_o_i[c] & yumi_i[c] & st_op_i[c];
            evt_fire[c][2] = v_o_i[c] & yumi_i[c] & ld_op_i[c] & miss_v_i[c];
            evt_fire[c][3] = v_o_i[c] & yumi_i[c] & st_op_i[c] & miss_v_i[c];
            evt_fire[c][4] = v_v_r_i[c] & miss_v_i[c] & ~(v_o_i[c] | yumi_i[c]);
        end
    end

    // On a clearing snapshot, this cycle's events seed the next interval.
    always_comb begin
        for (int c = 0; c < num_cache_p; c++) begin
            for (int e = 0; e < num_evt_lp; e++) begin
                if (snap_accept && (clear_on_snap_p != 0)) begin
                    live_d[c][e] = evt_fire[c][e] ? ctr_width_p'(1) : '0;
                end else if (evt_fire[c][e] && (live_q[c][e] != '1)) begin
                    live_d[c][e] = live_q[c][e] + ctr_width_p'(1);
                end else begin
                    live_d[c][e] = live_q[c][e];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            chan_q  <= '0;
            evt_q   <= '0;
            tag_q   <= '0;
            drop_q  <= '0;
            for (int c = 0; c < num_cache_p; c++) begin
                for (int e = 0; e < num_evt_lp; e++) begin
                    live_q[c][e]   <= '0;
                    shadow_q[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < num_cache_p; c++) begin
                for (int e = 0; e < num_evt_lp; e++) begin
                    live_q[c][e] <= live_d[c][e];
                end
            end
            case (state_q)
                IDLE: begin
                    if (snap_v_i) begin
                        for (int c = 0; c < num_cache_p; c++) begin
                            for (int e = 0; e < num_evt_lp; e++) begin
                                shadow_q[c][e] <= live_q[c][e];
                            end
                        end
                        tag_q   <= snap_tag_i;
                        chan_q  <= '0;
                        evt_q   <= '0;
                        state_q <= DUMP;
                    end
                end
                DUMP: begin
                    if (snap_v_i && (drop_q != '1)) begin
                        drop_q <= drop_q + ctr_width_p'(1);
                    end
                    if (dump_yumi_i) begin
                        if (last_rec) begin
                            state_q <= IDLE;
                            chan_q  <= '0;
                            evt_q   <= '0;
                        end else if (evt_q == 3'd4) begin
                            evt_q  <= '0;
                            chan_q <= chan_q + chan_w_lp'(1);
                        end else begin
                            evt_q <= evt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dump_count_o = '0;
        for (int c = 0; c < num_cache_p; c++) begin
            for (int e = 0; e < num_evt_lp; e++) begin
                if ((chan_q == chan_w_lp'(c)) && (evt_q == 3'(e))) begin
                    dump_count_o = shadow_q[c][e];
                end
            end
        end
    end

    assign busy_o      = (state_q == DUMP);
    assign dump_v_o    = (state_q == DUMP);
    assign dump_chan_o = chan_q;
    assign dump_evt_o  = evt_q;
    assign dump_tag_o  = tag_q;
    assign snap_drop_o = drop_q;

endmodule

// File: tb/tb_vcache_perf_counter_bank.sv
// Directed bench for vcache_perf_counter_bank: a clearing instance and a free-running instance,
// both with two channels and 4-bit counters so saturation is reachable quickly.
module tb_vcache_perf_counter_bank;

   localparam int NC = 2;
   localparam int CW = 4;
   localparam int TW = 8;
   localparam int NREC = NC * 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NC-1:0] vO = '0, yumi = '0, vVr = '0, missV = '0, ldOp = '0, stOp = '0;
   logic          snapV = 1'b0, snapVFr = 1'b0;
   logic [TW-1:0] snapTag = '0;
   logic          dumpYumi = 1'b0;

   logic          busy, dumpV, busyFr, dumpVFr;
   logic          dumpChan, dumpChanFr;
   logic [2:0]    dumpEvt, dumpEvtFr;
   logic [CW-1:0] dumpCount, dumpCountFr, snapDrop, snapDropFr;
   logic [TW-1:0] dumpTag, dumpTagFr;

   int numChecks = 0;
   int numFails = 0;
   int expCnt [NREC];

   vcache_perf_counter_bank #(
      .num_cache_p(NC), .ctr_width_p(CW), .tag_width_p(TW), .clear_on_snap_p(1)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .v_o_i(vO), .yumi_i(yumi), .v_v_r_i(vVr), .miss_v_i(missV),
      .ld_op_i(ldOp), .st_op_i(stOp),
      .snap_v_i(snapV), .snap_tag_i(snapTag),
      .busy_o(busy), .dump_v_o(dumpV), .dump_yumi_i(dumpYumi),
      .dump_chan_o(dumpChan), .dump_evt_o(dumpEvt), .dump_count_o(dumpCount),
      .dump_tag_o(dumpTag), .snap_drop_o(snapDrop)
   );

   vcache_perf_counter_bank #(
      .num_cache_p(NC), .ctr_width_p(CW), .tag_width_p(TW), .clear_on_snap_p(0)
   ) dutFr (
      .clk_i(clk), .reset_i(reset),
      .v_o_i(vO), .yumi_i(yumi), .v_v_r_i(vVr), .miss_v_i(missV),
      .ld_op_i(ldOp), .st_op_i(stOp),
      .snap_v_i(snapVFr), .snap_tag_i(snapTag),
      .busy_o(busyFr), .dump_v_o(dumpVFr), .dump_yumi_i(dumpYumi),
      .dump_chan_o(dumpChanFr), .dump_evt_o(dumpEvtFr), .dump_count_o(dumpCountFr),
      .dump_tag_o(dumpTagFr), .snap_drop_o(snapDropFr)
   );

   always #5 clk = ~clk;

   // Hard stop in case something wedges the sequence.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Hold an event pattern for a number of cycles, then return every event input to idle.
   task automatic applyStimulus(input logic [NC-1:0] v, input logic [NC-1:0] y, input logic [NC-1:0] vr,
                                input logic [NC-1:0] m, input logic [NC-1:0] ld, input logic [NC-1:0] st,
                                input int cycles);
      vO = v; yumi = y; vVr = vr; missV = m; ldOp = ld; stOp = st;
      repeat (cycles) tick();
      vO = '0; yumi = '0; vVr = '0; missV = '0; ldOp = '0; stOp = '0;
   endtask

   task automatic clearExp();
      for (int i = 0; i < NREC; i++) expCnt[i] = 0;
   endtask

   task automatic takeSnapshot(input bit fr, input logic [TW-1:0] tag);
      snapTag = tag;
      if (fr) snapVFr = 1'b1;
      else snapV = 1'b1;
      tick();
      snapV = 1'b0;
      snapVFr = 1'b0;
   endtask

   // Drain a full dump with yumi held high, comparing every record against expCnt.
   task automatic dumpAndCheck(input bit fr, input string name, input logic [TW-1:0] tag);
      checkOutput({name, " first valid"}, fr ? dumpVFr : dumpV, 1);
      dumpYumi = 1'b1;
      for (int i = 0; i < NREC; i++) begin
         checkOutput($sformatf("%s valid rec%0d", name, i), fr ? dumpVFr : dumpV, 1);
         checkOutput($sformatf("%s chan rec%0d", name, i), fr ? dumpChanFr : dumpChan, i / 5);
         checkOutput($sformatf("%s evt rec%0d", name, i), fr ? dumpEvtFr : dumpEvt, i % 5);
         checkOutput($sformatf("%s count rec%0d", name, i), fr ? dumpCountFr : dumpCount, expCnt[i]);
         checkOutput($sformatf("%s tag rec%0d", name, i), fr ? dumpTagFr : dumpTag, tag);
         tick();
      end
      dumpYumi = 1'b0;
      checkOutput({name, " busy after last"}, fr ? busyFr : busy, 0);
      checkOutput({name, " valid after last"}, fr ? dumpVFr : dumpV, 0);
   endtask

   initial begin
      int recs;

      // Reset values on every output.
      reset = 1'b1;
      repeat (2) tick();
      checkOutput("reset busy", busy, 0);
      checkOutput("reset dump_v", dumpV, 0);
      checkOutput("reset chan", dumpChan, 0);
      checkOutput("reset evt", dumpEvt, 0);
      checkOutput("reset count", dumpCount, 0);
      checkOutput("reset tag", dumpTag, 0);
      checkOutput("reset drop", snapDrop, 0);
      reset = 1'b0;
      tick();

      // Basic counts on channel 1: 3 ld hits, 4 miss cycles, 1 ld miss, 2 st hits.
      applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 3);
      applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 4);
      applyStimulus(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 1);
      applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2);
      tick();
      clearExp();
      expCnt[5] = 4; expCnt[6] = 2; expCnt[7] = 1; expCnt[8] = 0; expCnt[9] = 4;
      takeSnapshot(1'b0, 8'hA5);
      dumpAndCheck(1'b0, "basic", 8'hA5);

      // A load in the snapshot cycle belongs to the next interval.
      vO = 2'b01; yumi = 2'b01; ldOp = 2'b01;
      snapTag = 8'h01; snapV = 1'b1;
      tick();
      snapV = 1'b0; vO = '0; yumi = '0; ldOp = '0;
      clearExp();
      dumpAndCheck(1'b0, "sameCycle snap1", 8'h01);
      takeSnapshot(1'b0, 8'h02);
      expCnt[0] = 1;
      dumpAndCheck(1'b0, "sameCycle snap2", 8'h02);

      // Saturation: 20 loads into a 4-bit counter stick at 15.
      applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 20);
      takeSnapshot(1'b0, 8'h0F);
      clearExp();
      expCnt[0] = 15;
      dumpAndCheck(1'b0, "saturate", 8'h0F);

      // Back-pressure with random yumi and two snapshot requests dropped mid-dump.
      applyStimulus(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 1);
      clearExp();
      expCnt[1] = 1; expCnt[3] = 1;
      takeSnapshot(1'b0, 8'h3C);
      recs = 0;
      for (int it = 0; it < 400; it++) begin
         if (!dumpV) break;
         if (recs < NREC) begin
            checkOutput($sformatf("bp chan it%0d", it), dumpChan, recs / 5);
            checkOutput($sformatf("bp evt it%0d", it), dumpEvt, recs % 5);
            checkOutput($sformatf("bp count it%0d", it), dumpCount, expCnt[recs]);
            checkOutput($sformatf("bp tag it%0d", it), dumpTag, 8'h3C);
         end
         snapV = (it == 2 || it == 5);
         dumpYumi = 1'($urandom_range(0, 1));
         if (dumpYumi) recs++;
         tick();
      end
      snapV = 1'b0;
      dumpYumi = 1'b0;
      checkOutput("bp record count", recs, NREC);
      checkOutput("bp busy after", busy, 0);
      checkOutput("bp drops", snapDrop, 2);

      // Yumi while nothing is valid must not disturb the next dump.
      dumpYumi = 1'b1;
      tick();
      dumpYumi = 1'b0;
      checkOutput("stray yumi idle", dumpV, 0);

      // Reset in the middle of a dump.
      applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2);
      takeSnapshot(1'b0, 8'h11);
      dumpYumi = 1'b1;
      repeat (3) tick();
      checkOutput("midreset evt before", dumpEvt, 3);
      dumpYumi = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset dump_v", dumpV, 0);
      checkOutput("midreset busy", busy, 0);
      checkOutput("midreset drop", snapDrop, 0);
      tick();
      checkOutput("midreset stays idle", dumpV, 0);
      takeSnapshot(1'b0, 8'h22);
      clearExp();
      dumpAndCheck(1'b0, "postreset", 8'h22);

      // Free-running instance keeps accumulating across snapshots.
      applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 5);
      takeSnapshot(1'b1, 8'h55);
      clearExp();
      expCnt[0] = 5;
      dumpAndCheck(1'b1, "freerun snap1", 8'h55);
      applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2);
      takeSnapshot(1'b1, 8'h56);
      expCnt[0] = 7;
      dumpAndCheck(1'b1, "freerun snap2", 8'h56);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
